// File: rtl/harvard_bus_bridge.sv
// harvard_bus_bridge
// Serialises each cycle of the Harvard MIPS core onto one shared Avalon-style
// bus with waitrequest: instruction fetch, optional data access, then a
// one-cycle commit that pulses clk_enable so the core advances.
// Build option: define HARVARD_BUS_BRIDGE_TIMEOUT_EN to add a per-transfer
// waitrequest watchdog that parks the bridge in a sticky ERROR state.
`timescale 1ns/1ps
module harvard_bus_bridge #(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    output logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        bus_error
);

    // Stall count at which a still-stalled transfer is abandoned.
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_COMMIT, S_ERROR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_COMMIT} state_t;
`endif

    state_t      state_reg, state_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] data_reg, data_next;

    // Combinational bus request, shared by the lane generators below.
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_addr;

`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt_reg, wait_cnt_next;
`endif

    // State, latched words and watchdog counter; async reset abandons any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            instr_reg    <= '0;
            data_reg     <= '0;
`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            instr_reg    <= instr_next;
            data_reg     <= data_next;
`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
            wait_cnt_reg <= wait_cnt_next;
`endif
        end
    end

    // Sequencer: next state, bus request and latch enables from state and core inputs.
    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        data_next  = data_reg;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        bus_addr   = 32'h0;
        clk_enable = 1'b0;
`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
        wait_cnt_next = 16'h0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (active) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                bus_rd   = 1'b1;
                bus_addr = {instr_address[31:2], 2'b00};
                if (!waitrequest) begin
                    instr_next = readdata;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // A store takes priority when the core raises both requests.
                if (data_write) begin
                    bus_wr   = 1'b1;
                    bus_addr = {data_address[31:2], 2'b00};
                    if (!waitrequest) begin
                        state_next = S_COMMIT;
                    end
                end else if (data_read) begin
                    bus_rd   = 1'b1;
                    bus_addr = {data_address[31:2], 2'b00};
                    if (!waitrequest) begin
                        data_next  = readdata;
                        state_next = S_COMMIT;
                    end
                end else begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                clk_enable = 1'b1;
                state_next = active ? S_FETCH : S_IDLE;
            end
            default: begin
                // ERROR (watchdog builds): no request, only reset leaves.
            end
        endcase
`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
        // Count consecutive stalled edges of the current transfer; completion
        // or any non-transfer cycle clears the count for the next transfer.
        if ((bus_rd || bus_wr) && waitrequest) begin
            if (wait_cnt_reg >= WAIT_LAST) begin
                state_next = S_ERROR;
            end else begin
                wait_cnt_next = wait_cnt_reg + 16'd1;
            end
        end
`endif
    end

    // Byte lanes: all four enabled for any request, write data only on stores.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            assign byteenable[gi]      = bus_rd | bus_wr;
            assign writedata[8*gi +: 8] = bus_wr ? data_writedata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign read           = bus_rd;
    assign write          = bus_wr;
    assign address        = bus_addr;
    assign instr_readdata = instr_reg;
    assign data_readdata  = data_reg;

    // Word alignment drops the low address bits; collected here so they read as intentionally unused.
    logic unused_bits;
`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
    assign bus_error   = (state_reg == S_ERROR);
    assign unused_bits = ^{instr_address[1:0], data_address[1:0]};
`else
    assign bus_error   = 1'b0;
    assign unused_bits = ^{instr_address[1:0], data_address[1:0], WAIT_LAST};
`endif

endmodule

// File: tb/tb_harvard_bus_bridge.sv
// Testbench for harvard_bus_bridge: stimulus plays the core and the bus slave,
// a monitor collects completed bus transfers and checks each commit against
// an instruction-level reference queue.
`timescale 1ns/1ps
module tb_harvard_bus_bridge;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        active;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    harvard_bus_bridge #(.WAIT_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .active         (active),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .address        (address),
        .read           (read),
        .write          (write),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    // One expected instruction: what the bus must carry and what the core must see.
    typedef struct {
        logic [31:0] fetch_addr;
        logic [31:0] instr;
        int          kind;      // 0 none, 1 load, 2 store
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] exp_dr;
        int          cycles;    // 0 = not checked (first after idle/reset)
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } xfer_t;

    exp_t        exp_q[$];
    xfer_t       xfers[$];
    exp_t        mon_e;
    xfer_t       mon_x;
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic        proto_bad   = 1'b0;
    logic [31:0] model_dr    = 32'h0;
    bit          skip_next   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples just before each rising edge, gathers completed
    // transfers and checks them against the reference at each commit pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            xfers.delete();
            cyc       = 0;
            proto_bad = 1'b0;
        end else begin
            cyc++;
            if (read && write) proto_bad = 1'b1;
            if ((read || write) && (address[1:0] != 2'b00)) proto_bad = 1'b1;
            if (!read && !write && (address != 32'h0 || writedata != 32'h0 || byteenable != 4'h0))
                proto_bad = 1'b1;
            if (clk_enable && (read || write)) proto_bad = 1'b1;
            if ((read || write) && !waitrequest) begin
                mon_x.wr    = write;
                mon_x.addr  = address;
                mon_x.be    = byteenable;
                mon_x.wdata = writedata;
                xfers.push_back(mon_x);
            end
            if (clk_enable) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL commit_unexpected: clk_enable=1 with no instruction pending, required 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_readdata", instr_readdata, mon_e.instr);
                    check("data_readdata", data_readdata, mon_e.exp_dr);
                    if (mon_e.cycles > 0) check("cycles_per_instr", 32'(cyc), 32'(mon_e.cycles));
                    check("bus_protocol_ok", {31'h0, proto_bad}, 32'h0);
                    check("xfer_count", 32'(xfers.size()), (mon_e.kind != 0) ? 32'd2 : 32'd1);
                    if (xfers.size() >= 1) begin
                        check("fetch_is_read", {31'h0, xfers[0].wr}, 32'h0);
                        check("fetch_addr", xfers[0].addr, mon_e.fetch_addr);
                        check("fetch_be", {28'h0, xfers[0].be}, 32'hF);
                    end
                    if (mon_e.kind != 0 && xfers.size() >= 2) begin
                        check("data_is_write", {31'h0, xfers[1].wr}, (mon_e.kind == 2) ? 32'h1 : 32'h0);
                        check("data_addr", xfers[1].addr, mon_e.daddr);
                        check("data_be", {28'h0, xfers[1].be}, 32'hF);
                        if (mon_e.kind == 2) check("store_data", xfers[1].wdata, mon_e.wdata);
                    end
                end
                xfers.delete();
                cyc       = 0;
                proto_bad = 1'b0;
            end
        end
    end

    // Plays one core instruction plus the bus slave's wait states; entered
    // and left at the cycle the previous commit is on the bus.
    task automatic run_instr(input logic [31:0] ia, input logic [31:0] iw,
                             input logic dr, input logic dw,
                             input logic [31:0] da, input logic [31:0] wdat,
                             input logic [31:0] rdat, input int wf, input int wd,
                             input bit halt);
        exp_t e;
        int   guard;
        int   kind;
        kind = dw ? 2 : (dr ? 1 : 0);
        tick();
        instr_address  = ia;
        data_address   = da;
        data_read      = dr;
        data_write     = dw;
        data_writedata = wdat;
        if (kind == 1) model_dr = rdat;
        e.fetch_addr = ia & 32'hFFFF_FFFC;
        e.instr      = iw;
        e.kind       = kind;
        e.daddr      = da & 32'hFFFF_FFFC;
        e.wdata      = wdat;
        e.exp_dr     = model_dr;
        e.cycles     = skip_next ? 0 : 3 + wf + ((kind != 0) ? wd : 0);
        skip_next    = 1'b0;
        exp_q.push_back(e);
        guard = 0;
        while (!read && guard < 20) begin
            tick();
            guard++;
        end
        if (!read) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_start: read=0 after %0d cycles, required 1", guard);
            return;
        end
        repeat (wf) begin
            waitrequest = 1'b1;
            readdata    = $urandom;
            tick();
        end
        waitrequest = 1'b0;
        readdata    = iw;
        tick();
        if (halt) active = 1'b0;
        if (kind != 0) begin
            repeat (wd) begin
                waitrequest = 1'b1;
                readdata    = $urandom;
                tick();
            end
            waitrequest = 1'b0;
            readdata    = rdat;
            tick();
        end else begin
            waitrequest = 1'($urandom);
            readdata    = $urandom;
            tick();
        end
        waitrequest = 1'b1;
    endtask

    initial begin
        int n;
        int guard;
        int n_read;
        int n_ce;
        int n_err;

        rst_n          = 1'b0;
        active         = 1'b0;
        instr_address  = 32'h0;
        data_address   = 32'h0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'h0;
        waitrequest    = 1'b1;
        readdata       = 32'h0;
        repeat (3) tick();
        check("reset_ctrl", {28'h0, read, write, clk_enable, bus_error}, 32'h0);
        check("reset_address", address, 32'h0);
        check("reset_writedata", writedata, 32'h0);
        check("reset_byteenable", {28'h0, byteenable}, 32'h0);
        check("reset_instr_readdata", instr_readdata, 32'h0);
        check("reset_data_readdata", data_readdata, 32'h0);

        rst_n  = 1'b1;
        active = 1'b1;

        // Zero-wait ALU op, then load with 2 wait states, then store with both requests.
        repeat (3) run_instr(32'hBFC0_0000, 32'h2442_0005, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
        run_instr(32'hBFC0_0004, 32'h8C43_0004, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b0);
        run_instr(32'hBFC0_0008, 32'hAC43_0003, 1'b1, 1'b1, 32'h0000_1003, 32'h1234_5678, 32'h0, 0, 0, 1'b0);

        // Halt: active drops during EXEC of a load; one commit, then idle.
        run_instr(32'hBFC0_000C, 32'h3C01_1234, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b1);
        n = 0;
        repeat (12) begin
            tick();
            if (read || write || clk_enable) n++;
        end
        check("halt_idle_quiet", 32'(n), 32'h0);

        // Reset in the middle of a stalled fetch.
        active = 1'b1;
        guard  = 0;
        while (!read && guard < 20) begin
            tick();
            guard++;
        end
        check("midfetch_read_before", {31'h0, read}, 32'h1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", {28'h0, read, write, clk_enable, bus_error}, 32'h0);
        check("midreset_address", address, 32'h0);
        check("midreset_byteenable", {28'h0, byteenable}, 32'h0);
        check("midreset_instr_readdata", instr_readdata, 32'h0);
        check("midreset_data_readdata", data_readdata, 32'h0);
        tick();
        tick();
        model_dr  = 32'h0;
        skip_next = 1'b1;
        rst_n     = 1'b1;
        check("post_reset_idle_read", {31'h0, read}, 32'h0);
        tick();
        check("first_fetch_after_idle", {31'h0, read}, 32'h1);

        // Randomised instruction stream with random wait states.
        for (int i = 0; i < 40; i++) begin
            run_instr($urandom, $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
                      $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);
        end

        // Fetch that never completes.
        n_read = 0;
        n_ce   = 0;
        n_err  = 0;
        waitrequest = 1'b1;
        tick();
`ifdef HARVARD_BUS_BRIDGE_TIMEOUT_EN
        guard = 0;
        while (!bus_error && guard < 100) begin
            if (read) n_read++;
            if (clk_enable) n_ce++;
            tick();
            guard++;
        end
        check("wd_stall_cycles", 32'(n_read), 32'(TIMEOUT));
        check("wd_bus_error", {31'h0, bus_error}, 32'h1);
        check("wd_read_dropped", {31'h0, read}, 32'h0);
        check("wd_no_commit", 32'(n_ce), 32'h0);
        repeat (5) tick();
        check("wd_error_sticky", {28'h0, bus_error, read, write, clk_enable}, 32'h8);
`else
        repeat (300) begin
            if (read) n_read++;
            if (bus_error) n_err++;
            if (clk_enable) n_ce++;
            tick();
        end
        check("nowd_read_held", 32'(n_read), 32'd300);
        check("nowd_bus_error", 32'(n_err), 32'h0);
        check("nowd_no_commit", 32'(n_ce), 32'h0);
`endif
        rst_n = 1'b0;
        #1;
        check("final_reset_ctrl", {28'h0, read, write, clk_enable, bus_error}, 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
